// File: rtl/ring_buffer_pkg.sv
// Shared sizing helpers for the ring buffer FIFO.
package ring_buffer_pkg;

    // Index width for a storage array of the given depth (never narrower than 1 bit).
    function automatic int unsigned idx_width(input int unsigned depth);
        int unsigned w;
        w = $clog2(depth);
        return (w == 0) ? 1 : w;
    endfunction

    // Width of an occupancy counter able to hold the value depth itself.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ring_buffer_mem.sv
// DEPTH x WIDTH simple dual-port storage: synchronous write, asynchronous read.
module ring_buffer_mem
    import ring_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [idx_width(DEPTH)-1:0]  waddr,
    input  logic [WIDTH-1:0]             wdata,
    input  logic [idx_width(DEPTH)-1:0]  raddr,
    output logic [WIDTH-1:0]             rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Show-ahead read of the registered array.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/ring_buffer.sv
// Single-clock show-ahead FIFO organised as a ring buffer of arbitrary depth.
module ring_buffer
    import ring_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    output logic             full,
    output logic             empty,
    input  logic             in_shift,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_pop,
    output logic [WIDTH-1:0] out_data
);

    localparam int unsigned PW = idx_width(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [CW-1:0] count;
    logic [PW-1:0] wp_nxt;
    logic [PW-1:0] rp_nxt;
    logic [CW-1:0] count_nxt;
    logic          we;
    logic          re;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Accept/consume qualification and next-state computation.
    always_comb begin
        we        = in_shift & ~full;
        re        = out_pop & ~empty;
        wp_nxt    = wp;
        rp_nxt    = rp;
        count_nxt = count;
        if (we) begin
            wp_nxt = ptr_inc(wp);
        end
        if (re) begin
            rp_nxt = ptr_inc(rp);
        end
        unique case ({we, re})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointer, occupancy and flag registers; flags track the registered count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            wp    <= wp_nxt;
            rp    <= rp_nxt;
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    ring_buffer_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (wp),
        .wdata (in_data),
        .raddr (rp),
        .rdata (out_data)
    );

endmodule

// File: tb/tb_ring_buffer.sv
// Randomised and directed scoreboard bench for ring_buffer (DEPTH=5, WIDTH=8).
module tb_ring_buffer;

    localparam int unsigned DEPTH = 5;
    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             full;
    logic             empty;
    logic             in_shift;
    logic [WIDTH-1:0] in_data;
    logic             out_pop;
    logic [WIDTH-1:0] out_data;

    int pass_cnt = 0;
    int total    = 0;

    // Reference model: the FIFO contents as a plain queue.
    logic [WIDTH-1:0] q[$];
    bit               armed = 0;
    bit               soak  = 0;
    int               rcnt  = 0;
    int               wcnt  = 0;

    ring_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .full     (full),
        .empty    (empty),
        .in_shift (in_shift),
        .in_data  (in_data),
        .out_pop  (out_pop),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each accepted write/pop; the soak also checks the raw popped sequence.
    always @(posedge clk) begin
        int  n;
        bit  acc_w;
        bit  acc_r;
        if (rst) begin
            q.delete();
            armed = 1;
        end else if (armed) begin
            n     = q.size();
            acc_w = in_shift && (n < DEPTH);
            acc_r = out_pop && (n > 0);
            if (acc_r) begin
                if (soak) begin
                    chk("soak_seq", 32'(out_data), 32'(rcnt[7:0]));
                    rcnt++;
                end
                void'(q.pop_front());
            end
            if (acc_w) begin
                q.push_back(in_data);
            end
        end
    end

    // Monitor: flags and show-ahead head word against the model, mid-cycle.
    always @(negedge clk) begin
        if (armed) begin
            chk("empty", 32'(empty), 32'(q.size() == 0));
            chk("full", 32'(full), 32'(q.size() == DEPTH));
            if (q.size() > 0) begin
                chk("head", 32'(out_data), 32'(q[0]));
            end
        end
    end

    task automatic cycle(input logic s, input logic [WIDTH-1:0] d, input logic p);
        in_shift = s;
        in_data  = d;
        out_pop  = p;
        @(posedge clk);
        #1;
        in_shift = 1'b0;
        out_pop  = 1'b0;
    endtask

    task automatic pops(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1);
    endtask

    initial begin
        rst      = 1'b1;
        in_shift = 1'b0;
        in_data  = '0;
        out_pop  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_full", 32'(full), 32'd0);

        // Pop while empty is ignored.
        cycle(1'b0, '0, 1'b1);
        @(negedge clk);
        chk("pop_empty_ignored", 32'(empty), 32'd1);

        // Fill, overflow attempt, drain.
        for (int i = 0; i < 5; i++) cycle(1'b1, WIDTH'(i), 1'b0);
        @(negedge clk);
        chk("full_after_fill", 32'(full), 32'd1);
        cycle(1'b1, 8'd99, 1'b0);
        @(negedge clk);
        chk("overflow_head", 32'(out_data), 32'd0);
        pops(5);
        @(negedge clk);
        chk("empty_after_drain", 32'(empty), 32'd1);

        // Wrap-around: 4 rounds of 3 writes then 3 pops.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(r * 3 + i), 1'b0);
            pops(3);
        end

        // Simultaneous push/pop with two words stored.
        cycle(1'b1, 8'd100, 1'b0);
        cycle(1'b1, 8'd101, 1'b0);
        cycle(1'b1, 8'd7, 1'b1);
        @(negedge clk);
        chk("simul_head", 32'(out_data), 32'd101);
        pops(2);

        // Simultaneous push/pop when full: write rejected.
        for (int i = 0; i < 5; i++) cycle(1'b1, WIDTH'(10 + i), 1'b0);
        cycle(1'b1, 8'd55, 1'b1);
        @(negedge clk);
        chk("full_simul_not_full", 32'(full), 32'd0);
        chk("full_simul_head", 32'(out_data), 32'd11);
        pops(4);

        // Simultaneous push/pop when empty: pop rejected, no bypass.
        cycle(1'b1, 8'd5, 1'b1);
        @(negedge clk);
        chk("empty_simul_empty", 32'(empty), 32'd0);
        chk("empty_simul_data", 32'(out_data), 32'd5);
        pops(1);

        // Reset mid-operation discards stored words.
        for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(20 + i), 1'b0);
        rst = 1'b1;
        cycle(1'b0, '0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_empty", 32'(empty), 32'd1);
        cycle(1'b1, 8'd42, 1'b0);
        @(negedge clk);
        chk("midreset_data", 32'(out_data), 32'd42);
        pops(1);

        // Random soak with counting data.
        soak = 1;
        for (int c = 0; c < 5000; c++) begin
            bit s;
            bit p;
            s = ($urandom % 5) == 0;
            p = ($urandom % 5) == 0;
            if (s && q.size() < DEPTH) begin
                cycle(1'b1, WIDTH'(wcnt), p);
                wcnt++;
            end else begin
                cycle(1'b0, '0, p);
            end
        end
        while (q.size() > 0) pops(1);
        @(negedge clk);
        soak = 0;
        chk("soak_count", 32'(rcnt), 32'(wcnt));

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/ring_buffer.md
Name: ring_buffer

Overview:
- Synchronous FIFO with a ring-buffer organisation, parameterised depth and width. Used as elastic storage between a producer and a consumer in one clock domain.
- Reads are show-ahead (first-word-fall-through): the head word is presented on out_data while the buffer is non-empty and is consumed by out_pop.
- DEPTH need not be a power of two.

Parameters:
- DEPTH, 16, number of storage entries (≥2, any integer; the DEPTH=5 configuration is mandatory to support).
- WIDTH, 8, data word width in bits.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- full  out  1  high when DEPTH words are stored.
- empty  out  1  high when 0 words are stored.
- in_shift  in  1  write strobe; in_data is stored this cycle if not full.
- in_data  in  WIDTH  write data.
- out_pop  in  1  read strobe; consumes the head word if not empty.
- out_data  out  WIDTH  head word; valid whenever empty=0.

Behaviour:
- State:
  - write pointer wp and read pointer rp, each $clog2(DEPTH) bits, range 0..DEPTH-1.
  - occupancy count, $clog2(DEPTH+1) bits.
  - storage array mem[DEPTH] of WIDTH bits, not reset.
- Reset (rst=1 at a rising edge): wp=0, rp=0, count=0. The next cycle shows empty=1 and full=0. Reset has priority over in_shift and out_pop, and mid-operation it discards all stored words. mem contents are left unchanged.
- full = (count==DEPTH) and empty = (count==0). Both are decoded from registered count only, with no combinational path from the inputs.
- Write:
  - Effective write we = in_shift & ~full.
  - When we is set: mem[wp] <= in_data, and wp advances.
  - in_shift while full is ignored: no state change and no error flag.
- Read:
  - out_data = mem[rp], combinational read of the registered array.
  - Effective pop re = out_pop & ~empty. When re is set, rp advances.
  - out_pop while empty is ignored.
- Pointer advance wraps explicitly: next = (ptr==DEPTH-1) ? 0 : ptr+1. Modulo-2^n wrapping is forbidden.
- Count update:
  - we & ~re: count+1.
  - re & ~we: count-1.
  - both or neither: count unchanged.
- Simultaneous write and pop:
  - Non-empty and non-full: both happen; count and flags are unchanged.
  - Full: the pop happens and the write is rejected (full gates the write). The next cycle has count=DEPTH-1.
  - Empty: the write happens and the pop is rejected. There is no same-cycle bypass.
- Latency: a word written into an empty buffer appears on out_data with empty=0 one cycle after the write edge.
- out_data while empty=1 is don't-care. The bench must not check it.
- Ordering: words leave in exactly the order accepted. There is no loss or duplication across any number of wraps.

Decomposition:
- No shared package types are required. The pointer-increment-with-wrap is a local function.
- One optional sub-module, ring_buffer_mem: DEPTH×WIDTH simple dual-port storage with synchronous write and asynchronous read. Pointer, count and flag logic stay in ring_buffer.

Test Plan:
- Reset and empty (DEPTH=5, WIDTH=8): assert rst for 2 cycles -> empty=1, full=0. Pulse out_pop -> empty stays 1 and the state is unchanged.
- Fill and overflow: write 0,1,2,3,4 on consecutive cycles -> full=1 after the 5th. Then in_shift with data 99 -> ignored. Pop 5 times -> out_data reads 0,1,2,3,4, and empty=1 after the 5th pop.
- Wrap-around: write 3 and pop 3, repeated 4 times (pointers cross index 4→0 several times) -> sequence 0..11 emerges in order with no gaps.
- Simultaneous push/pop:
  - With count=2: push 7 and pop in the same cycle -> count stays 2 and the head advances.
  - When full: push and pop -> count becomes 4 and the pushed word is not stored.
  - When empty: push 5 and pop -> the pop is ignored, and out_data=5 with empty=0 the next cycle.
- Reset mid-operation: with 3 words stored, assert rst -> empty=1 next cycle. A new write of 42 -> out_data=42 one cycle later.
- Random soak: 5000 cycles with in_shift and out_pop each asserted at random about 20% of the time, each gated by full/empty -> the popped sequence is exactly 0,1,2,… mod 256 with no mismatch.
